multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the RV64 datapath.
- Sequences the PC register, PC select mux, ALU operand mux and writeback mux through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Performs the req/ready handshakes with instruction and data memory, with a bus timeout.
- Counts retired instructions and traps on illegal opcodes or bus timeout.

---
 rtl/multicycle_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV64 datapath: sequences fetch, decode, execute,
// memory and writeback, handles imem/dmem handshakes with a bus timeout, and counts retirements.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             dmem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             pc_write,
    output logic             branch,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             halted,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_NONE,
        C_R,
        C_I,
        C_LOAD,
        C_STORE,
        C_BR
    } class_t;

    state_t              r_state;
    class_t              r_class;
    logic [WAIT_W-1:0]   r_wait;
    logic [CNT_W-1:0]    r_instret;
    logic [1:0]          r_trapCause;

    class_t              w_decClass;
    logic                w_timeout;
    logic                w_imemReq;
    logic                w_irWrite;
    logic                w_dmemReq;
    logic                w_memRead;
    logic                w_memWrite;
    logic                w_pcWrite;
    logic                w_branch;
    logic                w_aluSrc;
    logic [1:0]          w_aluOp;
    logic                w_memToReg;
    logic                w_regWrite;
    logic                w_halted;

    // Branches only support BEQ/BNE; any other funct3 is treated as illegal.
    always_comb begin
        w_decClass = C_NONE;
        case (opcode)
            7'b0110011: w_decClass = C_R;
            7'b0010011: w_decClass = C_I;
            7'b0000011: w_decClass = C_LOAD;
            7'b0100011: w_decClass = C_STORE;
            7'b1100011: w_decClass = (funct3 == 3'b000 || funct3 == 3'b001) ? C_BR : C_NONE;
            default:    w_decClass = C_NONE;
        endcase
    end

    assign w_timeout = (TIMEOUT > 0) && (r_wait == TIMEOUT_V);

    always_comb begin
        w_imemReq  = 1'b0;
        w_irWrite  = 1'b0;
        w_dmemReq  = 1'b0;
        w_memRead  = 1'b0;
        w_memWrite = 1'b0;
        w_pcWrite  = 1'b0;
        w_branch   = 1'b0;
        w_aluSrc   = 1'b0;
        w_aluOp    = 2'b00;
        w_memToReg = 1'b0;
        w_regWrite = 1'b0;
        w_halted   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imemReq = 1'b1;
                w_irWrite = imem_ready;
            end
            S_EXECUTE: begin
                case (r_class)
                    C_R: w_aluOp = 2'b10;
                    C_I: begin
                        w_aluSrc = 1'b1;
                        w_aluOp  = 2'b10;
                    end
                    C_LOAD, C_STORE: w_aluSrc = 1'b1;
                    C_BR: begin
                        w_aluOp   = 2'b01;
                        w_pcWrite = 1'b1;
                        w_branch  = (funct3 == 3'b000) ? zero : ~zero;
                    end
                    default: ;
                endcase
            end
            // Operand mux is held so the effective address stays stable across the wait.
            S_MEM: begin
                w_dmemReq  = 1'b1;
                w_memRead  = (r_class == C_LOAD);
                w_memWrite = (r_class == C_STORE);
                w_aluSrc   = 1'b1;
                w_pcWrite  = (r_class == C_STORE) && dmem_ready;
            end
            S_WRITEBACK: begin
                w_regWrite = 1'b1;
                w_pcWrite  = 1'b1;
                w_memToReg = (r_class == C_LOAD);
            end
            S_TRAP: w_halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_class     <= C_NONE;
            r_wait      <= '0;
            r_instret   <= '0;
            r_trapCause <= 2'b00;
        end else begin
            r_wait <= '0;
            if (w_pcWrite) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state     <= S_TRAP;
                        r_trapCause <= 2'b10;
                    end else if (TIMEOUT > 0) begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    r_class <= w_decClass;
                    if (w_decClass == C_NONE) begin
                        r_state     <= S_TRAP;
                        r_trapCause <= 2'b01;
                    end else begin
                        r_state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    case (r_class)
                        C_BR:            r_state <= S_FETCH;
                        C_LOAD, C_STORE: r_state <= S_MEM;
                        default:         r_state <= S_WRITEBACK;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        r_state <= (r_class == C_LOAD) ? S_WRITEBACK : S_FETCH;
                    end else if (w_timeout) begin
                        r_state     <= S_TRAP;
                        r_trapCause <= 2'b11;
                    end else if (TIMEOUT > 0) begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                S_WRITEBACK: r_state <= S_FETCH;
                S_TRAP:      r_state <= S_TRAP;
                default:     r_state <= S_FETCH;
            endcase
        end
    end

    // Reset forces every output low immediately, even mid-handshake.
    assign imem_req   = ~reset & w_imemReq;
    assign ir_write   = ~reset & w_irWrite;
    assign dmem_req   = ~reset & w_dmemReq;
    assign mem_read   = ~reset & w_memRead;
    assign mem_write  = ~reset & w_memWrite;
    assign pc_write   = ~reset & w_pcWrite;
    assign branch     = ~reset & w_branch;
    assign alu_src    = ~reset & w_aluSrc;
    assign alu_op     = reset ? 2'b00 : w_aluOp;
    assign mem_to_reg = ~reset & w_memToReg;
    assign reg_write  = ~reset & w_regWrite;
    assign halted     = ~reset & w_halted;
    assign trap_cause = reset ? 2'b00 : r_trapCause;
    assign instret    = reset ? '0 : r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: an instruction-level reference model predicts
// every cycle's control outputs and the retirement count for directed and random programs.
module tb_multicycle_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic       imemReq;
        logic       irWrite;
        logic       dmemReq;
        logic       memRead;
        logic       memWrite;
        logic       pcWrite;
        logic       branch;
        logic       aluSrc;
        logic [1:0] aluOp;
        logic       memToReg;
        logic       regWrite;
        logic       halted;
        logic [1:0] trapCause;
    } outs_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          zero;
    logic          imem_ready;
    logic          dmem_ready;
    logic          imem_req, ir_write, dmem_req, mem_read, mem_write, pc_write;
    logic          branch, alu_src, mem_to_reg, reg_write, halted;
    logic [1:0]    alu_op, trap_cause;
    logic [CW-1:0] instret;

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] expInstret = '0;
    logic [1:0]    expCause = 2'b00;

    multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .dmem_req(dmem_req),
        .mem_read(mem_read), .mem_write(mem_write), .pc_write(pc_write),
        .branch(branch), .alu_src(alu_src), .alu_op(alu_op), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .halted(halted), .trap_cause(trap_cause), .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic checkOutput(input string tag, input outs_t e);
        outs_t got;
        got = {imem_req, ir_write, dmem_req, mem_read, mem_write, pc_write, branch,
               alu_src, alu_op, mem_to_reg, reg_write, halted, trap_cause};
        checks++;
        assert (got === e) else begin
            errors++;
            $error("[TB] FAIL %s outputs: got=%h want=%h", tag, got, e);
        end
        checks++;
        assert (instret === expInstret) else begin
            errors++;
            $error("[TB] FAIL %s instret: got=%0d want=%0d", tag, instret, expInstret);
        end
    endtask

    // Inputs are driven just after a falling edge, outputs checked 1ns later.
    task automatic applyStimulus(input string tag, input outs_t e, input logic imr, input logic dmr);
        imem_ready = imr;
        dmem_ready = dmr;
        #1;
        checkOutput(tag, e);
        if (e.pcWrite && !reset) expInstret = expInstret + CW'(1);
        @(negedge clk);
    endtask

    task automatic doReset();
        outs_t e;
        e = '0;
        reset = 1'b1;
        expInstret = '0;
        expCause = 2'b00;
        applyStimulus("reset0", e, rb(), rb());
        applyStimulus("reset1", e, rb(), rb());
        reset = 1'b0;
    endtask

    task automatic holdTrap(input int n);
        outs_t e;
        for (int i = 0; i < n; i++) begin
            e = '0;
            e.halted = 1'b1;
            e.trapCause = expCause;
            opcode = 7'($urandom);
            zero = rb();
            applyStimulus("trap", e, rb(), rb());
        end
    endtask

    // Runs one instruction; fw/mw are the number of not-ready cycles before ready.
    task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                            input int fw, input int mw, input int resetInMem, output bit stop);
        outs_t e;
        bit isR, isI, isLd, isSt, isBr;
        isR  = (op == 7'b0110011);
        isI  = (op == 7'b0010011);
        isLd = (op == 7'b0000011);
        isSt = (op == 7'b0100011);
        isBr = (op == 7'b1100011) && (f3 == 3'b000 || f3 == 3'b001);
        stop = 1'b0;
        funct3 = 3'($urandom);
        zero = rb();
        for (int k = 0; k <= TO; k++) begin
            opcode = 7'($urandom);
            e = '0;
            e.imemReq = 1'b1;
            e.irWrite = (k == fw);
            applyStimulus("fetch", e, (k == fw), rb());
            if (k == fw) break;
            if (k == TO) begin
                expCause = 2'b10;
                stop = 1'b1;
                return;
            end
        end
        opcode = op;
        funct3 = f3;
        e = '0;
        applyStimulus("decode", e, rb(), rb());
        if (!(isR || isI || isLd || isSt || isBr)) begin
            expCause = 2'b01;
            stop = 1'b1;
            return;
        end
        zero = z;
        e = '0;
        if (isR) e.aluOp = 2'b10;
        if (isI) begin
            e.aluSrc = 1'b1;
            e.aluOp = 2'b10;
        end
        if (isLd || isSt) e.aluSrc = 1'b1;
        if (isBr) begin
            e.aluOp = 2'b01;
            e.pcWrite = 1'b1;
            e.branch = (f3 == 3'b000) ? z : !z;
        end
        applyStimulus("execute", e, rb(), rb());
        if (isBr) return;
        zero = rb();
        if (isLd || isSt) begin
            for (int k = 0; k <= TO; k++) begin
                if (k == resetInMem) begin
                    stop = 1'b1;
                    return;
                end
                e = '0;
                e.dmemReq = 1'b1;
                e.memRead = isLd;
                e.memWrite = isSt;
                e.aluSrc = 1'b1;
                e.pcWrite = isSt && (k == mw);
                applyStimulus("mem", e, rb(), (k == mw));
                if (k == mw) begin
                    if (isSt) return;
                    break;
                end
                if (k == TO) begin
                    expCause = 2'b11;
                    stop = 1'b1;
                    return;
                end
            end
        end
        e = '0;
        e.regWrite = 1'b1;
        e.pcWrite = 1'b1;
        e.memToReg = isLd;
        applyStimulus("writeback", e, rb(), rb());
    endtask

    initial begin
        bit stop;
        logic [6:0] ops [0:5];
        logic [6:0] op;
        int fw, mw;
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1111111;
        reset = 1'b1;
        opcode = '0;
        funct3 = '0;
        zero = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        $display("[TB] starting multicycle_ctrl bench");
        @(negedge clk);
        doReset();

        runInstr(7'b0110011, 3'b000, 1'b0, 0, 0, -1, stop);
        runInstr(7'b0000011, 3'b011, 1'b0, 0, 2, -1, stop);
        runInstr(7'b1100011, 3'b000, 1'b1, 0, 0, -1, stop);
        runInstr(7'b1100011, 3'b001, 1'b1, 1, 0, -1, stop);
        runInstr(7'b0100011, 3'b011, 1'b0, 2, 1, -1, stop);

        runInstr(7'b1111111, 3'b000, 1'b0, 0, 0, -1, stop);
        holdTrap(20);
        doReset();

        runInstr(7'b1100011, 3'b010, 1'b0, 0, 0, -1, stop);
        holdTrap(3);
        doReset();

        runInstr(7'b0110011, 3'b000, 1'b0, TO + 1, 0, -1, stop);
        holdTrap(3);
        doReset();
        runInstr(7'b0110011, 3'b000, 1'b0, TO, 0, -1, stop);

        runInstr(7'b0000011, 3'b000, 1'b0, 0, TO + 1, -1, stop);
        holdTrap(3);
        doReset();
        runInstr(7'b0000011, 3'b000, 1'b0, 0, TO, -1, stop);

        runInstr(7'b0100011, 3'b010, 1'b0, 0, 5, 1, stop);
        doReset();

        for (int n = 0; n < 80; n++) begin
            op = ops[$urandom_range(0, 5)];
            fw = ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(0, 3);
            mw = ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(0, 3);
            runInstr(op, 3'($urandom), rb(), fw, mw, -1, stop);
            if (stop) begin
                holdTrap(2);
                doReset();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
